// File: rtl/nes_button_conditioner.sv
// NES button conditioner: debounce, press/release strobes,
// typematic repeat and controller-connected tracking.
module nes_button_conditioner #(
  parameter int DEBOUNCE_SAMPLES = 2,
  parameter int REPEAT_DELAY     = 20,
  parameter int REPEAT_RATE      = 6,
  parameter int TIMEOUT_FRAMES   = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_buttons,
  input  logic       i_frame_tick,
  output logic [7:0] o_held,
  output logic [7:0] o_pressed,
  output logic [7:0] o_released,
  output logic [7:0] o_repeat,
  output logic       o_connected
);

  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_SAMPLES - 1);
  localparam logic [7:0] RD      = 8'(REPEAT_DELAY);
  localparam logic [7:0] RR      = 8'(REPEAT_RATE);
  localparam logic [7:0] TO      = 8'(TIMEOUT_FRAMES);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_FRAMES - 1);

  logic [7:0]      held, held_n;
  logic [7:0]      pressed, pressed_n;
  logic [7:0]      released, released_n;
  logic [7:0]      rpt, rpt_n;
  logic            conn, conn_n;
  logic [7:0]      tcnt, tcnt_n;
  logic [7:0][3:0] dcnt, dcnt_n;
  logic [7:0][7:0] rcnt, rcnt_n;
  logic            good;
  logic            timeout;

  // Next-state: connection timer, per-bit debounce and repeat timers
  always_comb begin
    good       = i_valid && (i_buttons != 8'hFF);
    timeout    = 1'b0;
    held_n     = held;
    pressed_n  = '0;
    released_n = '0;
    rpt_n      = '0;
    conn_n     = conn;
    tcnt_n     = tcnt;
    dcnt_n     = dcnt;
    rcnt_n     = rcnt;

    if (good) begin
      conn_n = 1'b1;
      tcnt_n = '0;
    end else if (i_frame_tick && conn) begin
      if (tcnt >= TO_LAST) begin
        timeout = 1'b1;
        tcnt_n  = TO;
      end else begin
        tcnt_n = tcnt + 8'd1;
      end
    end

    for (int i = 0; i < 8; i++) begin
      if (good) begin
        if (i_buttons[i] == held[i]) begin
          dcnt_n[i] = '0;
        end else if (dcnt[i] == DB_LAST) begin
          dcnt_n[i]     = '0;
          held_n[i]     = i_buttons[i];
          pressed_n[i]  = i_buttons[i];
          released_n[i] = ~i_buttons[i];
        end else if (dcnt[i] != 4'hF) begin
          dcnt_n[i] = dcnt[i] + 4'd1;
        end
      end

      if (pressed_n[i]) begin
        rpt_n[i]  = 1'b1;
        rcnt_n[i] = RD;
      end else if (released_n[i]) begin
        rcnt_n[i] = '0;
      end else if (i_frame_tick && held[i]
                   && rcnt[i] != 8'd0) begin
        if (rcnt[i] == 8'd1) begin
          rpt_n[i]  = 1'b1;
          rcnt_n[i] = RR;
        end else begin
          rcnt_n[i] = rcnt[i] - 8'd1;
        end
      end
    end

    // Disconnect drops every held bit and flushes all timers
    if (timeout) begin
      conn_n     = 1'b0;
      held_n     = '0;
      pressed_n  = '0;
      released_n = held;
      rpt_n      = '0;
      dcnt_n     = '0;
      rcnt_n     = '0;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      held     <= '0;
      pressed  <= '0;
      released <= '0;
      rpt      <= '0;
      conn     <= 1'b0;
      tcnt     <= '0;
      dcnt     <= '0;
      rcnt     <= '0;
    end else begin
      held     <= held_n;
      pressed  <= pressed_n;
      released <= released_n;
      rpt      <= rpt_n;
      conn     <= conn_n;
      tcnt     <= tcnt_n;
      dcnt     <= dcnt_n;
      rcnt     <= rcnt_n;
    end
  end

  assign o_held      = held;
  assign o_pressed   = pressed;
  assign o_released  = released;
  assign o_repeat    = rpt;
  assign o_connected = conn;

endmodule

// File: tb/tb_nes_button_conditioner.sv
// Bench for nes_button_conditioner: frame-level model
// compared every cycle, plus literal spot checks.
module tb_nes_button_conditioner;

  localparam int DB    = 2;
  localparam int DELAY = 20;
  localparam int RATE  = 6;
  localparam int TO    = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] buttons = 8'h00;
  logic       tick = 1'b0;

  logic [7:0] held, pressed, released, rpt;
  logic       connected;
  logic [7:0] held0, pressed0, released0, rpt0;
  logic       connected0;

  int checks = 0;
  int errors = 0;

  // model state
  logic [7:0] e_held, e_pressed, e_released;
  logic [7:0] e_rpt, e_rpt0;
  logic       e_conn;
  int         silent;
  int         run [8];
  int         ticks [8];

  always #5 clk = ~clk;

  nes_button_conditioner dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid),
    .i_buttons(buttons), .i_frame_tick(tick),
    .o_held(held), .o_pressed(pressed),
    .o_released(released), .o_repeat(rpt),
    .o_connected(connected)
  );

  nes_button_conditioner #(.REPEAT_RATE(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid),
    .i_buttons(buttons), .i_frame_tick(tick),
    .o_held(held0), .o_pressed(pressed0),
    .o_released(released0), .o_repeat(rpt0),
    .o_connected(connected0)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic model_reset();
    e_held = 0; e_pressed = 0; e_released = 0;
    e_rpt = 0; e_rpt0 = 0; e_conn = 0; silent = 0;
    for (int i = 0; i < 8; i++) begin
      run[i] = 0; ticks[i] = -1;
    end
  endtask

  task automatic model(input logic rst, input logic v,
                       input logic [7:0] b, input logic t);
    logic good, tmo, was, flip;
    if (!rst) begin
      model_reset();
      return;
    end
    good = v && (b != 8'hFF);
    tmo = !good && t && e_conn && (silent + 1 >= TO);
    e_pressed = 0; e_released = 0; e_rpt = 0; e_rpt0 = 0;
    if (good) begin
      silent = 0; e_conn = 1;
    end else if (t && e_conn) begin
      silent++;
    end
    if (tmo) begin
      e_released = e_held;
      e_held = 0;
      e_conn = 0;
      for (int i = 0; i < 8; i++) begin
        run[i] = 0; ticks[i] = -1;
      end
      return;
    end
    for (int i = 0; i < 8; i++) begin
      was = e_held[i];
      flip = 0;
      if (good) begin
        if (b[i] != was) begin
          run[i]++;
          if (run[i] == DB) begin
            e_held[i] = b[i]; run[i] = 0; flip = 1;
          end
        end else begin
          run[i] = 0;
        end
      end
      if (flip && e_held[i]) begin
        e_pressed[i] = 1; e_rpt[i] = 1; e_rpt0[i] = 1;
        ticks[i] = 0;
      end else if (flip) begin
        e_released[i] = 1; ticks[i] = -1;
      end else if (was && t && ticks[i] >= 0) begin
        ticks[i]++;
        if (ticks[i] == DELAY) begin
          e_rpt[i] = 1; e_rpt0[i] = 1;
        end else if (ticks[i] > DELAY
                     && (ticks[i] - DELAY) % RATE == 0) begin
          e_rpt[i] = 1;
        end
      end
    end
  endtask

  task automatic compare();
    chk("held", 64'(held), 64'(e_held));
    chk("pressed", 64'(pressed), 64'(e_pressed));
    chk("released", 64'(released), 64'(e_released));
    chk("repeat", 64'(rpt), 64'(e_rpt));
    chk("connected", 64'(connected), 64'(e_conn));
    chk("held_r0", 64'(held0), 64'(e_held));
    chk("repeat_r0", 64'(rpt0), 64'(e_rpt0));
    chk("conn_r0", 64'(connected0), 64'(e_conn));
  endtask

  task automatic step(input logic r, input logic v,
                      input logic [7:0] b, input logic t);
    @(negedge clk);
    rst_n = r; valid = v; buttons = b; tick = t;
    @(posedge clk);
    model(r, v, b, t);
    #1;
    compare();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] mask, mask0;
    logic [7:0]  pat [6];
    pat[0] = 8'h00; pat[1] = 8'h01; pat[2] = 8'h80;
    pat[3] = 8'hFF; pat[4] = 8'h81; pat[5] = 8'h10;
    model_reset();

    // reset
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    chk("rst_held", 64'(held), 64'h0);
    chk("rst_conn", 64'(connected), 64'h0);

    // two-sample debounce of bit 0
    step(1, 1, 8'h01, 0);
    chk("first_held", 64'(held), 64'h0);
    chk("first_conn", 64'(connected), 64'h1);
    step(1, 0, 8'h00, 1);
    step(1, 1, 8'h01, 0);
    chk("press_p", 64'(pressed), 64'h01);
    chk("press_r", 64'(rpt), 64'h01);
    chk("press_h", 64'(held), 64'h01);
    step(1, 0, 8'h00, 0);
    chk("press_1cyc", 64'(pressed), 64'h00);

    // single glitch on bit 1 is ignored
    step(1, 1, 8'h03, 0);
    step(1, 1, 8'h01, 0);
    step(1, 1, 8'h03, 0);
    step(1, 1, 8'h01, 0);
    chk("glitch_h", 64'(held), 64'h01);
    chk("glitch_p", 64'(pressed), 64'h00);

    // hold bit 3 and count repeat ticks
    step(1, 1, 8'h09, 0);
    step(1, 1, 8'h09, 0);
    chk("b3_press", 64'(pressed), 64'h08);
    mask = 0; mask0 = 0;
    for (int k = 1; k <= 34; k++) begin
      step(1, 0, 8'h00, 1);
      if (rpt[3]) mask[k] = 1'b1;
      if (rpt0[3]) mask0[k] = 1'b1;
      step(1, 1, 8'h09, 0);
    end
    chk("rep_ticks", mask,
        (64'd1 << 20) | (64'd1 << 26) | (64'd1 << 32));
    chk("rep0_ticks", mask0, 64'd1 << 20);
    step(1, 1, 8'h01, 0);
    step(1, 1, 8'h01, 0);
    chk("b3_rel", 64'(released), 64'h08);
    mask = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1, 0, 8'h00, 1);
      if (rpt[3]) mask[k] = 1'b1;
      step(1, 1, 8'h01, 0);
    end
    chk("b3_norep", mask, 64'h0);

    // press of bit 0 coincident with a frame tick
    step(1, 1, 8'h00, 0);
    step(1, 1, 8'h00, 0);
    step(1, 1, 8'h01, 0);
    step(1, 1, 8'h01, 1);
    chk("coin_p", 64'(pressed), 64'h01);
    mask = 0;
    for (int k = 1; k <= 21; k++) begin
      step(1, 0, 8'h00, 1);
      if (rpt[0]) mask[k] = 1'b1;
      step(1, 1, 8'h01, 0);
    end
    chk("coin_ticks", mask, 64'd1 << 20);

    // timeout with only floating reads
    step(1, 1, 8'h90, 0);
    step(1, 1, 8'h90, 0);
    chk("to_held", 64'(held), 64'h90);
    for (int k = 1; k <= 8; k++) begin
      step(1, 1, 8'hFF, 0);
      step(1, 0, 8'h00, 1);
      if (k < 8) begin
        chk("to_hold", 64'(held), 64'h90);
        chk("to_conn", 64'(connected), 64'h1);
      end
    end
    chk("to_drop", 64'(connected), 64'h0);
    chk("to_zero", 64'(held), 64'h00);
    chk("to_rel", 64'(released), 64'h90);
    step(1, 0, 8'h00, 1);
    chk("to_rel1", 64'(released), 64'h00);

    // reconnect
    step(1, 1, 8'h00, 0);
    chk("re_conn", 64'(connected), 64'h1);
    chk("re_strobe",
        64'({pressed, released, rpt}), 64'h0);
    step(1, 1, 8'h00, 0);

    // reset mid-operation
    step(1, 1, 8'h24, 0);
    step(1, 1, 8'h24, 0);
    for (int k = 0; k < 22; k++) begin
      step(1, 0, 8'h00, 1);
      step(1, 1, 8'h24, 0);
    end
    chk("pre_rst", 64'(held), 64'h24);
    step(0, 0, 8'h00, 0);
    chk("mid_rst",
        64'({held, pressed, released, rpt}), 64'h0);
    chk("mid_rst_c", 64'(connected), 64'h0);
    step(1, 0, 8'h00, 0);
    chk("mid_rst_rel", 64'(released), 64'h00);

    // mixed traffic against the model
    for (int k = 0; k < 400; k++) begin
      step(1, ($urandom_range(0, 3) != 0),
           pat[$urandom_range(0, 5)],
           ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nes_button_conditioner.md
Name: nes_button_conditioner

Overview:
- Sits between `nes_controller` and the game-logic consumers (ball, paddle, menu blocks).
- Takes the raw per-frame button snapshot (`o_valid`/`o_buttons`) and produces the following, all on a single clock:
  - debounced held levels;
  - one-cycle press and release strobes;
  - typematic auto-repeat strobes;
  - a controller-connected flag.
- Replaces the bare `r_buttons` capture register in the top levels.

Parameters:
- DEBOUNCE_SAMPLES, 2: consecutive valid samples that must agree before a held bit changes (1 = immediate; legal 1..15).
- REPEAT_DELAY, 20: frame ticks from press to first repeat strobe (legal 1..255).
- REPEAT_RATE, 6: frame ticks between subsequent repeat strobes (0 = repeat disabled, legal 0..255).
- TIMEOUT_FRAMES, 8: frame ticks without a good sample before the controller is declared disconnected (legal 1..255).

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  synchronous active-low reset
- i_valid  input  1  one-cycle strobe: i_buttons holds a fresh sample
- i_buttons  input  8  raw sample, active-high, bit order per nes_controller.vh NES_BUTTON_* defines
- i_frame_tick  input  1  one-cycle per-frame strobe (vblank rising edge)
- o_held  output  8  debounced button levels
- o_pressed  output  8  one-cycle strobe per bit on debounced 0->1
- o_released  output  8  one-cycle strobe per bit on debounced 1->0
- o_repeat  output  8  one-cycle strobe: on press, then typematic repeats while held
- o_connected  output  1  high while good samples keep arriving

Behaviour:
- Reset (i_rst_n low at a clock edge), registered state: all outputs 0; debounce counters, repeat counters and timeout counter 0. Reset mid-operation discards all state, and no release strobes are emitted.
- All outputs are registered.
- A sample accepted at edge N is reflected in o_held, o_pressed, o_released and o_repeat at edge N+1 (latency 1).
- Strobes are high for exactly one cycle.
- Good sample: i_valid=1 and i_buttons != 8'hFF.
- 8'hFF is a floating-line or disconnected read. On such a sample:
  - held state and debounce counters are unchanged;
  - the timeout counter is not cleared.
- Debounce, per bit, evaluated only on good samples:
  - If sample bit == held bit: clear that bit's counter.
  - Otherwise: if counter == DEBOUNCE_SAMPLES-1, flip the held bit, clear the counter and emit a pressed/released strobe. If not, increment the counter.
  - DEBOUNCE_SAMPLES=1 flips on the first differing sample.
- Repeat, per bit; each bit has an 8-bit frame-down-counter:
  - On the debounced press: o_repeat pulses together with o_pressed, and the counter loads REPEAT_DELAY.
  - On i_frame_tick while the bit is held and the counter is nonzero:
    - if counter == 1: pulse o_repeat and load REPEAT_RATE;
    - else decrement.
  - REPEAT_RATE=0: after the first repeat the counter stays 0, so no further strobes.
  - Release clears the counter.
  - Press and i_frame_tick in the same cycle: the press wins and the tick is ignored for that bit.
  - Release and tick in the same cycle: no repeat strobe.
- Connection and timeout:
  - A good sample sets o_connected=1 (next edge) and clears the timeout counter.
  - Each i_frame_tick while o_connected=1 increments the timeout counter.
  - When the counter would reach TIMEOUT_FRAMES:
    - o_connected drops to 0;
    - o_held is forced to 0, with o_released strobing every previously held bit in that same cycle;
    - debounce and repeat counters are cleared.
  - Good sample and tick in the same cycle: the sample wins and the counter is cleared.
  - While o_connected=0, good samples update debounce normally (reconnect path).
- Width rules:
  - All counters saturate and never wrap.
  - The timeout counter stops at TIMEOUT_FRAMES.
  - Debounce counters are 4 bits.

Test Plan:
- Reset then DEBOUNCE_SAMPLES=2: good samples 8'h01, 8'h01 (one per frame) -> o_pressed=8'h01 one cycle after the 2nd sample; o_held=8'h01; o_repeat=8'h01 same cycle; single sample 8'h01 followed by 8'h00 -> no strobe.
- Hold bit 3 with REPEAT_DELAY=20, REPEAT_RATE=6, one tick per frame -> o_repeat[3] pulses at press, then at tick 20, 26, 32; release -> o_released[3] pulse, repeats stop; REPEAT_RATE=0 -> only the tick-20 repeat.
- Press of bit 0 coincident with i_frame_tick -> repeat counter = REPEAT_DELAY (not REPEAT_DELAY-1); first repeat still exactly 20 ticks later.
- o_held=8'h90, then only 8'hFF samples for 8 ticks -> o_held unchanged during ticks 1-7; at tick 8 o_connected=0, o_held=0, o_released=8'h90 single cycle.
- After disconnect, good samples 8'h00 -> o_connected=1 one cycle after the first; no spurious strobes.
- Assert i_rst_n=0 for one cycle while o_held=8'hFF-free nonzero value and repeats are active -> next cycle all outputs 0, no o_released pulse.
